// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge
// ---------------------------------------------------------------------------
// Bridges an AHB-Lite slave port to an APB master. Each sampled NONSEQ/SEQ
// transfer becomes one APB SETUP + ACCESS pair. The AHB master is stalled
// through hreadyout until the APB access phase.
//
// Optional feature macro: AHB_APB_ERR_RESP_EN
//   defined   : out-of-range transfers get a two-cycle AHB ERROR response
//   undefined : out-of-range transfers are ignored (zero wait, OKAY)
//
// Ports
//   hclk, hresetn            clock, asynchronous active-low reset
//   hwrite, hreadyin, htrans AHB control (address phase)
//   haddr, hwdata            AHB address / write data (data phase)
//   prdata                   APB read data
//   hreadyout, hresp, hrdata AHB response
//   pselx, penable, pwrite   APB control (pselx is one-hot, 3 slaves)
//   paddr, pwdata            APB address / write data
//   fsm_state                debug view of the bridge FSM state
//
// Handshake: an AHB transfer is accepted on a rising edge where hreadyin=1,
// htrans is NONSEQ or SEQ, and the bridge is in IDLE, WENABLE or RENABLE
// (the states that drive hreadyout=1). APB has no pready: ACCESS is always
// exactly one cycle.
// ---------------------------------------------------------------------------
module ahb_apb_bridge (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hwrite,
  input  logic        hreadyin,
  input  logic [1:0]  htrans,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [31:0] prdata,
  output logic        hreadyout,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  output logic [2:0]  pselx,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WWAIT   = 3'd1,
    S_WRITE   = 3'd2,
    S_WENABLE = 3'd3,
    S_READ    = 3'd4,
`ifdef AHB_APB_ERR_RESP_EN
    S_RENABLE = 3'd5,
    S_ERR1    = 3'd6,
    S_ERR2    = 3'd7
`else
    S_RENABLE = 3'd5
`endif
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  sel_q;

  // Address decode: 0x80.. / 0x84.. / 0x88.. windows of 64 MB each.
  logic        in_range;
  logic [2:0]  dec_sel;
  logic        req;
  logic        valid;

  always_comb begin
    dec_sel = 3'b000;
    if (haddr[31:28] == 4'h8) begin
      case (haddr[27:26])
        2'b00:   dec_sel = 3'b001;
        2'b01:   dec_sel = 3'b010;
        2'b10:   dec_sel = 3'b100;
        default: dec_sel = 3'b000;
      endcase
    end
  end

  assign in_range = |dec_sel;
  assign req      = hreadyin & htrans[1];   // NONSEQ (2) or SEQ (3)
  assign valid    = req & in_range;

  assign fsm_state = state;

  // Read data is passed straight through only during the ACCESS phase so the
  // master sees it in the same cycle hreadyout rises.
  assign hrdata = (state == S_RENABLE) ? prdata : 32'h0;

`ifdef AHB_APB_ERR_RESP_EN
  logic [1:0] hresp_q;
  assign hresp = hresp_q;
`else
  assign hresp = 2'b00;
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state     <= S_IDLE;
      hreadyout <= 1'b1;
      pselx     <= 3'b000;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= 32'h0;
      pwdata    <= 32'h0;
      addr_q    <= 32'h0;
      sel_q     <= 3'b000;
`ifdef AHB_APB_ERR_RESP_EN
      hresp_q   <= 2'b00;
`endif
    end else begin
      case (state)
        // IDLE and both ENABLE states sample the next transfer identically.
        S_IDLE, S_WENABLE, S_RENABLE: begin
          penable <= 1'b0;
          if (valid) begin
            addr_q <= haddr;
            sel_q  <= dec_sel;
            hreadyout <= 1'b0;
            if (hwrite) begin
              // Write data arrives one cycle later; pselx is left as is so a
              // back-to-back transfer keeps the slave selected.
              state <= S_WWAIT;
            end else begin
              state  <= S_READ;
              pselx  <= dec_sel;
              pwrite <= 1'b0;
              paddr  <= haddr;
            end
          end
`ifdef AHB_APB_ERR_RESP_EN
          else if (req) begin
            state     <= S_ERR1;
            hreadyout <= 1'b0;
            hresp_q   <= 2'b01;
            pselx     <= 3'b000;
            pwrite    <= 1'b0;
          end
`endif
          else begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            pselx     <= 3'b000;
            pwrite    <= 1'b0;
          end
        end

        S_WWAIT: begin
          state     <= S_WRITE;
          hreadyout <= 1'b0;
          pselx     <= sel_q;
          pwrite    <= 1'b1;
          penable   <= 1'b0;
          paddr     <= addr_q;
          pwdata    <= hwdata;
        end

        S_WRITE: begin
          state     <= S_WENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end

        S_READ: begin
          state     <= S_RENABLE;
          penable   <= 1'b1;
          hreadyout <= 1'b1;
        end

`ifdef AHB_APB_ERR_RESP_EN
        S_ERR1: begin
          state     <= S_ERR2;
          hreadyout <= 1'b1;
          hresp_q   <= 2'b01;
        end

        // Second cycle of the ERROR response; no transfer is sampled here.
        S_ERR2: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          hresp_q   <= 2'b00;
        end
`endif

        default: begin
          state     <= S_IDLE;
          hreadyout <= 1'b1;
          pselx     <= 3'b000;
          penable   <= 1'b0;
          pwrite    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb_ahb_apb_bridge
// Directed bench for ahb_apb_bridge. Inputs change 1 ns after each rising
// edge; outputs are checked at that same point (after the edge has settled).
module tb_ahb_apb_bridge;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WWAIT   = 3'd1;
  localparam logic [2:0] ST_WRITE   = 3'd2;
  localparam logic [2:0] ST_WENABLE = 3'd3;
  localparam logic [2:0] ST_READ    = 3'd4;
  localparam logic [2:0] ST_RENABLE = 3'd5;

  logic        hclk;
  logic        hresetn;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [31:0] prdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [2:0]  pselx;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [2:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ahb_apb_bridge dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hwrite    (hwrite),
    .hreadyin  (hreadyin),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwdata    (hwdata),
    .prdata    (prdata),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata),
    .pselx     (pselx),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive_idle();
    htrans   = 2'd0;
    hwrite   = 1'b0;
    hreadyin = 1'b1;
  endtask

  task automatic drive_addr(input logic [31:0] a, input logic w);
    haddr    = a;
    hwrite   = w;
    htrans   = 2'd2;
    hreadyin = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    hresetn = 1'b0;
    drive_idle();
    haddr = 32'h0; hwdata = 32'h0; prdata = 32'h0;
    repeat (2) @(posedge hclk);
    #1;
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %b exp 1", hreadyout); end
    checks++; if (hresp !== 2'b00) begin errors++; $display("FAIL rst_hresp got %b exp 00", hresp); end
    checks++; if (pselx !== 3'b000) begin errors++; $display("FAIL rst_pselx got %b exp 000", pselx); end
    checks++; if (penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", penable); end
    checks++; if (paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h exp 0", paddr); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", hrdata); end
    checks++; if (pwdata !== 32'h0 || pwrite !== 1'b0) begin errors++; $display("FAIL rst_pwdata got %h/%b exp 0/0", pwdata, pwrite); end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    int low_cnt;
    low_cnt = 0;
    drive_addr(32'h8000_0001, 1'b1);
    tick();                                    // edge T: now WWAIT
    if (hreadyout === 1'b0) low_cnt++;
    checks++; if (fsm_state !== ST_WWAIT) begin errors++; $display("FAIL wr_wwait_state got %0d exp %0d", fsm_state, ST_WWAIT); end
    checks++; if (pselx !== 3'b000) begin errors++; $display("FAIL wr_wwait_pselx got %b exp 000", pselx); end
    drive_idle();
    hwdata = 32'h80;
    tick();                                    // T+1: WRITE
    if (hreadyout === 1'b0) low_cnt++;
    hwdata = 32'hFFFF_FFFF;                    // must not reach pwdata
    checks++; if (pselx !== 3'b001) begin errors++; $display("FAIL wr_setup_pselx got %b exp 001", pselx); end
    checks++; if (paddr !== 32'h8000_0001) begin errors++; $display("FAIL wr_setup_paddr got %h exp 80000001", paddr); end
    checks++; if (pwdata !== 32'h80) begin errors++; $display("FAIL wr_setup_pwdata got %h exp 00000080", pwdata); end
    checks++; if (pwrite !== 1'b1 || penable !== 1'b0) begin errors++; $display("FAIL wr_setup_ctl got pwrite=%b penable=%b exp 1/0", pwrite, penable); end
    tick();                                    // T+2: WENABLE
    if (hreadyout === 1'b0) low_cnt++;
    checks++; if (penable !== 1'b1 || hreadyout !== 1'b1) begin errors++; $display("FAIL wr_access got penable=%b hreadyout=%b exp 1/1", penable, hreadyout); end
    checks++; if (pselx !== 3'b001 || pwdata !== 32'h80) begin errors++; $display("FAIL wr_access_hold got %b/%h exp 001/00000080", pselx, pwdata); end
    checks++; if (low_cnt != 2) begin errors++; $display("FAIL wr_wait_cycles got %0d exp 2", low_cnt); end
    tick();                                    // back to IDLE
    checks++; if (pselx !== 3'b000 || penable !== 1'b0 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL wr_release got pselx=%b penable=%b state=%0d exp 000/0/0", pselx, penable, fsm_state); end
  endtask

  task automatic test_single_read();
    logic [31:0] exp;
    int low_cnt;
    low_cnt = 0;
    exp_q.push_back(32'hDEAD_BEEF);
    prdata = 32'hDEAD_BEEF;
    drive_addr(32'h8400_0010, 1'b0);
    tick();                                    // READ
    if (hreadyout === 1'b0) low_cnt++;
    checks++; if (pselx !== 3'b010 || pwrite !== 1'b0 || penable !== 1'b0) begin errors++; $display("FAIL rd_setup got pselx=%b pwrite=%b penable=%b exp 010/0/0", pselx, pwrite, penable); end
    checks++; if (paddr !== 32'h8400_0010) begin errors++; $display("FAIL rd_setup_paddr got %h exp 84000010", paddr); end
    checks++; if (hrdata !== 32'h0) begin errors++; $display("FAIL rd_setup_hrdata got %h exp 0", hrdata); end
    drive_idle();
    tick();                                    // RENABLE
    if (hreadyout === 1'b0) low_cnt++;
    exp = exp_q.pop_front();
    checks++; if (hrdata !== exp || hreadyout !== 1'b1) begin errors++; $display("FAIL rd_data got %h/%b exp %h/1", hrdata, hreadyout, exp); end
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rd_access_penable got %b exp 1", penable); end
    checks++; if (low_cnt != 1) begin errors++; $display("FAIL rd_wait_cycles got %0d exp 1", low_cnt); end
    tick();
    checks++; if (pselx !== 3'b000 || hrdata !== 32'h0) begin errors++; $display("FAIL rd_release got %b/%h exp 000/0", pselx, hrdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    exp_q.push_back(32'h1357_9BDF);
    prdata = 32'h1357_9BDF;
    drive_addr(32'h8800_0000, 1'b0);
    tick();                                    // READ
    checks++; if (pselx !== 3'b100) begin errors++; $display("FAIL b2b_rd_pselx got %b exp 100", pselx); end
    drive_idle();
    tick();                                    // RENABLE
    exp = exp_q.pop_front();
    checks++; if (hrdata !== exp) begin errors++; $display("FAIL b2b_rd_data got %h exp %h", hrdata, exp); end
    drive_addr(32'h8800_0004, 1'b1);           // write issued in RENABLE
    tick();                                    // WWAIT directly
    checks++; if (fsm_state !== ST_WWAIT) begin errors++; $display("FAIL b2b_state got %0d exp %0d", fsm_state, ST_WWAIT); end
    checks++; if (pselx !== 3'b100 || penable !== 1'b0 || hreadyout !== 1'b0) begin errors++; $display("FAIL b2b_hold got pselx=%b penable=%b hreadyout=%b exp 100/0/0", pselx, penable, hreadyout); end
    drive_idle();
    hwdata = 32'h0000_1234;
    tick();                                    // WRITE
    checks++; if (paddr !== 32'h8800_0004 || pwdata !== 32'h1234 || pwrite !== 1'b1) begin errors++; $display("FAIL b2b_wr_setup got %h/%h/%b exp 88000004/00001234/1", paddr, pwdata, pwrite); end
    tick();                                    // WENABLE
    checks++; if (fsm_state !== ST_WENABLE || penable !== 1'b1) begin errors++; $display("FAIL b2b_wr_access got %0d/%b exp %0d/1", fsm_state, penable, ST_WENABLE); end
    tick();
  endtask

  task automatic test_non_transfers();
    logic [1:0] tr_tab [3];
    logic       rdy_tab[3];
    tr_tab[0] = 2'd0; rdy_tab[0] = 1'b1;
    tr_tab[1] = 2'd1; rdy_tab[1] = 1'b1;
    tr_tab[2] = 2'd2; rdy_tab[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      haddr    = 32'h8000_0100;
      hwrite   = i[0];
      htrans   = tr_tab[i];
      hreadyin = rdy_tab[i];
      tick();
      checks++; if (pselx !== 3'b000 || hreadyout !== 1'b1 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL nontrans_%0d got pselx=%b hreadyout=%b state=%0d exp 000/1/0", i, pselx, hreadyout, fsm_state); end
    end
    drive_idle();
    tick();
  endtask

  task automatic test_range_edges();
    // Last word of the third window is still selected.
    drive_addr(32'h8BFF_FFFC, 1'b0);
    tick();
    checks++; if (pselx !== 3'b100 || fsm_state !== ST_READ) begin errors++; $display("FAIL edge_hi got %b/%0d exp 100/%0d", pselx, fsm_state, ST_READ); end
    drive_idle();
    tick();
    tick();
    drive_addr(32'h83FF_FFFF, 1'b0);
    tick();
    checks++; if (pselx !== 3'b001) begin errors++; $display("FAIL edge_win0_top got %b exp 001", pselx); end
    drive_idle();
    tick();
    tick();
  endtask

  task automatic test_out_of_range();
    drive_addr(32'h9000_0000, 1'b1);
    tick();
`ifdef AHB_APB_ERR_RESP_EN
    checks++; if (hresp !== 2'b01 || hreadyout !== 1'b0) begin errors++; $display("FAIL oor_err1 got %b/%b exp 01/0", hresp, hreadyout); end
    drive_idle();
    hwdata = 32'hAAAA_5555;
    tick();
    checks++; if (hresp !== 2'b01 || hreadyout !== 1'b1) begin errors++; $display("FAIL oor_err2 got %b/%b exp 01/1", hresp, hreadyout); end
    checks++; if (pselx !== 3'b000 || penable !== 1'b0) begin errors++; $display("FAIL oor_apb got %b/%b exp 000/0", pselx, penable); end
    tick();
    checks++; if (hresp !== 2'b00 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL oor_done got %b/%0d exp 00/0", hresp, fsm_state); end
`else
    checks++; if (hresp !== 2'b00 || hreadyout !== 1'b1) begin errors++; $display("FAIL oor_ignore got %b/%b exp 00/1", hresp, hreadyout); end
    checks++; if (pselx !== 3'b000 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL oor_nosel got %b/%0d exp 000/0", pselx, fsm_state); end
    drive_addr(32'h8C00_0000, 1'b0);           // first address past the map
    hwdata = 32'hAAAA_5555;
    tick();
    checks++; if (pselx !== 3'b000 || hreadyout !== 1'b1 || pwdata === 32'hAAAA_5555) begin errors++; $display("FAIL oor_edge got %b/%b/%h exp 000/1/not-aaaa5555", pselx, hreadyout, pwdata); end
    drive_idle();
    tick();
`endif
  endtask

  task automatic test_reset_mid_transfer();
    drive_addr(32'h8400_0020, 1'b1);
    tick();                                    // WWAIT
    drive_idle();
    hwdata = 32'h0BAD_F00D;
    tick();                                    // WRITE
    tick();                                    // WENABLE
    checks++; if (fsm_state !== ST_WENABLE || penable !== 1'b1) begin errors++; $display("FAIL amid_pre got %0d/%b exp %0d/1", fsm_state, penable, ST_WENABLE); end
    #2;
    hresetn = 1'b0;
    #1;                                        // still well before the next edge
    checks++; if (penable !== 1'b0 || pselx !== 3'b000) begin errors++; $display("FAIL amid_async got penable=%b pselx=%b exp 0/000", penable, pselx); end
    checks++; if (hreadyout !== 1'b1 || paddr !== 32'h0 || pwdata !== 32'h0 || fsm_state !== ST_IDLE) begin errors++; $display("FAIL amid_clear got %b/%h/%h/%0d exp 1/0/0/0", hreadyout, paddr, pwdata, fsm_state); end
    tick();
    hresetn = 1'b1;
    tick();
    checks++; if (fsm_state !== ST_IDLE || hreadyout !== 1'b1) begin errors++; $display("FAIL amid_after got %0d/%b exp 0/1", fsm_state, hreadyout); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_non_transfers();
    test_range_edges();
    test_out_of_range();
    test_reset_mid_transfer();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
